// File: rtl/moving_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : moving_avg_ctrl
// Purpose  : Sequencer for one moving-average engine: clear / warm-up / run
//            control, sample pacing, settled-average output with sticky
//            overrun. Define MAVG_CTRL_STATS_EN to add the drop_cnt port.
// Revision : 1.0  initial release
// ============================================================================
module moving_avg_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CLR_CYCLES = 2,
    parameter int MIN_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_wr,
    input  logic [2:0]            cfg_mode,
    input  logic                  cfg_orm,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  eng_rst_n,
    output logic                  eng_enable,
    output logic                  eng_refresh,
    output logic [DATA_WIDTH-1:0] eng_din,
    output logic [2:0]            eng_mode,
    output logic                  eng_orm,
    input  logic [DATA_WIDTH-1:0] eng_dout,
    input  logic                  eng_pulse,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  ovr_clr,
    output logic                  overrun,
    output logic                  busy
`ifdef MAVG_CTRL_STATS_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    // Bit 1 of the state encoding means "engine out of reset and enabled".
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_CLEAR  = 2'b01;
    localparam logic [1:0] S_WARMUP = 2'b10;
    localparam logic [1:0] S_RUN    = 2'b11;

    localparam logic [3:0] C_CLR_LAST = 4'(CLR_CYCLES - 1);
    localparam logic [3:0] C_GAP_LOAD = 4'(MIN_GAP - 1);
    localparam logic [4:0] C_IDX_MAX  = 5'd16;

    logic [1:0]            r_state;
    logic [3:0]            r_clr_cnt;
    logic [3:0]            r_gap_cnt;
    logic [2:0]            r_mode;
    logic                  r_orm;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_refresh;
    logic                  r_tag1;
    logic                  r_tag2;
    logic [4:0]            r_idx;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_overrun;

    logic [1:0] w_nxt;
    logic [4:0] w_warm_len;
    logic [4:0] w_idx_inc;
    logic       w_active;
    logic       w_hs;
    logic       w_abort;
    logic       w_acc;
    logic       w_flush;
    logic       w_pulse_ok;
    logic       w_take;
    logic       w_ovr_ev;

    always_comb begin
        w_warm_len = 5'd1;
        case (r_mode)
            3'b001:         w_warm_len = 5'd2;
            3'b010:         w_warm_len = 5'd3;
            3'b011:         w_warm_len = 5'd4;
            3'b100, 3'b101: w_warm_len = 5'd16;
            default:        w_warm_len = 5'd1;
        endcase
    end

    assign w_active  = r_state[1];
    assign w_hs      = s_valid && s_ready;
    assign w_abort   = cfg_wr || stop;
    assign w_acc     = w_hs && !w_abort;
    assign w_idx_inc = (r_idx == C_IDX_MAX) ? C_IDX_MAX : r_idx + 5'd1;

    always_comb begin
        w_nxt = r_state;
        if (stop && (r_state != S_IDLE)) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_nxt = S_CLEAR;
                S_CLEAR:  if (!cfg_wr && (r_clr_cnt == 4'd0)) w_nxt = S_WARMUP;
                S_WARMUP: begin
                    if (cfg_wr)                   w_nxt = S_CLEAR;
                    else if (r_idx >= w_warm_len) w_nxt = S_RUN;
                end
                S_RUN:    if (cfg_wr) w_nxt = S_CLEAR;
                default:  w_nxt = S_IDLE;
            endcase
        end
    end

    // Anything in flight is discarded whenever the engine is about to be held in reset.
    assign w_flush    = !w_nxt[1];
    assign w_pulse_ok = eng_pulse && r_tag2 && w_active && !w_flush;
    assign w_take     = w_pulse_ok && (!r_m_valid || m_ready);
    assign w_ovr_ev   = w_pulse_ok && r_m_valid && !m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= 4'd0;
            r_gap_cnt <= 4'd0;
            r_mode    <= 3'b000;
            r_orm     <= 1'b0;
            r_din     <= '0;
            r_refresh <= 1'b0;
            r_tag1    <= 1'b0;
            r_tag2    <= 1'b0;
            r_idx     <= 5'd0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_nxt;

            if (cfg_wr) begin
                r_mode <= cfg_mode;
                r_orm  <= cfg_orm;
            end

            if ((w_nxt == S_CLEAR) && ((r_state != S_CLEAR) || cfg_wr))
                r_clr_cnt <= C_CLR_LAST;
            else if ((r_state == S_CLEAR) && (r_clr_cnt != 4'd0))
                r_clr_cnt <= r_clr_cnt - 4'd1;

            r_refresh <= w_acc;
            if (w_acc)
                r_din <= s_data;

            if (w_flush) begin
                r_gap_cnt <= 4'd0;
                r_idx     <= 5'd0;
                r_tag1    <= 1'b0;
                r_tag2    <= 1'b0;
            end else begin
                if (w_acc)
                    r_gap_cnt <= C_GAP_LOAD;
                else if (r_gap_cnt != 4'd0)
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                if (w_acc)
                    r_idx <= w_idx_inc;
                r_tag1 <= w_acc && (w_idx_inc >= w_warm_len);
                r_tag2 <= r_tag1;
            end

            if (w_flush) begin
                r_m_valid <= 1'b0;
            end else if (w_take) begin
                r_m_valid <= 1'b1;
                r_m_data  <= eng_dout;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (w_ovr_ev)
                r_overrun <= 1'b1;
            else if (ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    assign s_ready     = w_active && (r_gap_cnt == 4'd0);
    assign eng_rst_n   = w_active;
    assign eng_enable  = w_active;
    assign eng_refresh = r_refresh;
    assign eng_din     = r_din;
    assign eng_mode    = r_mode;
    assign eng_orm     = r_orm;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);

`ifdef MAVG_CTRL_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [1:0]  w_drop_inc;
    logic [16:0] w_drop_sum;

    assign w_drop_inc = {1'b0, w_hs && w_abort} + {1'b0, w_ovr_ev};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= 16'd0;
        else if (w_drop_inc != 2'd0)
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        else if (ovr_clr)
            r_drop_cnt <= 16'd0;
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moving_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_avg_ctrl
// Purpose  : Scoreboard bench for moving_avg_ctrl with a behavioural engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_moving_avg_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, cfg_wr, cfg_orm;
    logic [2:0]    cfg_mode;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          eng_rst_n, eng_enable, eng_refresh, eng_orm;
    logic [DW-1:0] eng_din;
    logic [2:0]    eng_mode;
    logic [DW-1:0] eng_dout = '0;
    logic          eng_pulse = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          ovr_clr;
    logic          overrun;
    logic          busy;
`ifdef MAVG_CTRL_STATS_EN
    logic [15:0]   drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    moving_avg_ctrl #(.DATA_WIDTH(DW), .CLR_CYCLES(2), .MIN_GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_orm(cfg_orm),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .eng_rst_n(eng_rst_n), .eng_enable(eng_enable), .eng_refresh(eng_refresh),
        .eng_din(eng_din), .eng_mode(eng_mode), .eng_orm(eng_orm),
        .eng_dout(eng_dout), .eng_pulse(eng_pulse),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .ovr_clr(ovr_clr), .overrun(overrun), .busy(busy)
`ifdef MAVG_CTRL_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event required none", nm);
    endtask

    // Averaging window and warm-up length are both N by mode.
    function automatic int win(input logic [2:0] m);
        case (m)
            3'b001:         return 2;
            3'b010:         return 3;
            3'b011:         return 4;
            3'b100, 3'b101: return 16;
            default:        return 1;
        endcase
    endfunction

    // Behavioural engine: one-cycle latency mean over the last N samples since reset.
    int eng_hist[$];
    int ew, en, es;
    always @(posedge clk) begin
        if (!eng_rst_n) begin
            eng_hist.delete();
            eng_pulse <= 1'b0;
        end else begin
            eng_pulse <= eng_refresh;
            if (eng_refresh) begin
                eng_hist.push_back(int'($signed(eng_din)));
                ew = win(eng_mode);
                en = (eng_hist.size() < ew) ? eng_hist.size() : ew;
                es = 0;
                for (int i = eng_hist.size() - en; i < eng_hist.size(); i++) es += eng_hist[i];
                eng_dout <= 16'(es / en);
            end
        end
    end

    // Reference model: settled output = mean of last N accepted samples once N reached.
    int            hist[$];
    int            exp_q[$];
    logic [DW-1:0] ref_q[$];
    logic [2:0]    mdl_mode = 3'b000;
    bit            sb_en = 1'b1;
    int            mw, ms;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (s_valid && s_ready && !cfg_wr && !stop) begin
                ref_q.push_back(s_data);
                hist.push_back(int'($signed(s_data)));
                mw = win(mdl_mode);
                if (sb_en && hist.size() >= mw) begin
                    ms = 0;
                    for (int i = hist.size() - mw; i < hist.size(); i++) ms += hist[i];
                    exp_q.push_back(ms / mw);
                end
            end
            if (cfg_wr) mdl_mode = cfg_mode;
            if (cfg_wr || stop || start) begin
                hist.delete();
                exp_q.delete();
            end
        end
    end

    // Monitor: refresh content and output handshakes against the scoreboard.
    always @(negedge clk) begin
        if (eng_refresh) begin
            if (ref_q.size() == 0) flag("spurious_refresh");
            else check("eng_din", {16'd0, eng_din}, {16'd0, ref_q.pop_front()});
        end
        if (sb_en && m_valid && m_ready) begin
            if (exp_q.size() == 0) flag("unexpected_m_valid");
            else check("m_data", {16'd0, m_data}, {16'd0, 16'(exp_q.pop_front())});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_cfg(input logic [2:0] m, input logic o);
        cfg_wr = 1'b1; cfg_mode = m; cfg_orm = o;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v);
        bit ok = 1'b0;
        s_valid = 1'b1; s_data = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
        end
        if (!ok) flag("send_timeout");
        tick();
        s_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_s();
        int v;
        v = int'($urandom_range(0, 40000)) - 20000;
        return v[DW-1:0];
    endfunction

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
        end
        if (!ok) flag("ready_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rm;
        logic       ro;
        rst = 1'b1; start = 0; stop = 0; cfg_wr = 0; cfg_mode = 0; cfg_orm = 0;
        s_valid = 0; s_data = 0; m_ready = 1; ovr_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_eng_rst_n", eng_rst_n, 0);
        check("rst_eng_enable", eng_enable, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_eng_mode", eng_mode, 0);
        check("rst_eng_refresh", eng_refresh, 0);
        tick();

        // Start timing: two clear cycles, ready on the third cycle after start.
        pulse_cfg(3'b001, 1'b1);
        start = 1'b1;
        @(negedge clk);
        check("start_c0_busy", busy, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_c1_rst_n", eng_rst_n, 0);
        check("start_c1_busy", busy, 1);
        @(negedge clk);
        check("start_c2_rst_n", eng_rst_n, 0);
        check("start_c2_s_ready", s_ready, 0);
        @(negedge clk);
        check("start_c3_rst_n", eng_rst_n, 1);
        check("start_c3_s_ready", s_ready, 1);
        check("start_c3_enable", eng_enable, 1);
        check("shadow_mode", eng_mode, 1);
        check("shadow_orm", eng_orm, 1);
        tick();

        send(16'd100); send(16'd200); send(16'd300);
        wait_cyc(6);
        check("drain_mode1", exp_q.size(), 0);

        // Mode 101: nothing until the 16th sample.
        pulse_cfg(3'b101, 1'b0);
        repeat (15) send(16'd1000);
        wait_cyc(4);
        check("warm16_m_valid", m_valid, 0);
        send(16'd1000);
        wait_cyc(5);
        check("drain_mode5", exp_q.size(), 0);

        // Overrun: second output lost while the first is still pending.
        pulse_cfg(3'b000, 1'b0);
        sb_en = 1'b0;
        m_ready = 1'b0;
        send(16'd500);
        send(16'hFD44);
        wait_cyc(4);
        @(negedge clk);
        check("ovr_m_valid", m_valid, 1);
        check("ovr_m_data", m_data, 500);
        check("ovr_flag", overrun, 1);
        tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        check("ovr_m_data_kept", m_data, 500);
        tick();
        m_ready = 1'b1;
        tick();
        @(negedge clk);
        check("ovr_drained", m_valid, 0);
        tick();
        sb_en = 1'b1;

        // cfg_wr in RUN coinciding with a handshake; warm-up of 4 restarts.
        s_valid = 1'b1; s_data = rnd_s();
        wait_ready();
        tick(); s_data = rnd_s();
        tick(); s_data = rnd_s();
        cfg_wr = 1'b1; cfg_mode = 3'b011; cfg_orm = 1'b0;
        @(negedge clk);
        check("cfgwr_hs_ready", s_ready, 1);
        tick();
        cfg_wr = 1'b0; s_data = rnd_s();
        @(negedge clk);
        check("cfgwr_rst_n_a", eng_rst_n, 0);
        check("cfgwr_no_refresh", eng_refresh, 0);
        tick(); s_data = rnd_s();
        @(negedge clk);
        check("cfgwr_rst_n_b", eng_rst_n, 0);
        repeat (16) begin
            tick();
            s_data = rnd_s();
        end
        s_valid = 1'b0;
        wait_cyc(6);
        check("drain_mode3", exp_q.size(), 0);

        // stop and cfg_wr together with a handshake sample.
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        s_valid = 1'b1; s_data = rnd_s();
        wait_ready();
        tick();
        tick();
        stop = 1'b1; cfg_wr = 1'b1; cfg_mode = 3'b010;
        @(negedge clk);
        check("stopcfg_hs_ready", s_ready, 1);
        tick();
        stop = 1'b0; cfg_wr = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("stopcfg_busy", busy, 0);
        check("stopcfg_mode", eng_mode, 2);
        check("stopcfg_rst_n", eng_rst_n, 0);
`ifdef MAVG_CTRL_STATS_EN
        check("stopcfg_drop_cnt", drop_cnt, 1);
`endif
        tick();

        // Randomized runs across modes.
        for (int r = 0; r < 4; r++) begin
            rm = 3'($urandom_range(0, 7));
            ro = 1'($urandom_range(0, 1));
            pulse_cfg(rm, ro);
            check("rnd_mode", eng_mode, rm);
            pulse_start();
            repeat (24) begin
                wait_cyc($urandom_range(0, 2));
                send(rnd_s());
            end
            wait_cyc(6);
            check("drain_rnd", exp_q.size(), 0);
            stop = 1'b1; tick(); stop = 1'b0;
        end

        // Asynchronous reset mid-operation with an output pending.
        pulse_cfg(3'b000, 1'b0);
        pulse_start();
        sb_en = 1'b0;
        m_ready = 1'b0;
        send(16'd11); send(16'd22);
        wait_cyc(3);
        @(negedge clk);
        check("prerst_m_valid", m_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_overrun", overrun, 0);
        check("async_rst_rst_n", eng_rst_n, 0);
        tick();
        rst = 1'b0;
        hist.delete(); exp_q.delete(); ref_q.delete();
        mdl_mode = 3'b000;
        m_ready = 1'b1;
        sb_en = 1'b1;
        tick();
        pulse_start();
        send(16'd7);
        send(16'hFFF9);
        wait_cyc(5);
        check("drain_post_rst", exp_q.size(), 0);
        check("refresh_q_empty", ref_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
